usb_da_stream_fifo: RTL and testbench

Parametrised dual-clock stream buffer between the USB3 (FX3) receive path and the DA sample path. Words are captured in the `wrclock` domain whenever the USB read FSM reports its data phase. A falling edge on `USB3_FLAGA` triggers a fixed-length read burst in the `rdclock` domain. Gray-coded pointer crossing provides true full/empty detection, with sticky overflow and underrun status flags.

---
 rtl/usb_da_pkg.sv | 40 ++++
 rtl/sdp_ram_2clk.sv | 48 ++++
 rtl/usb_da_stream_fifo.sv | 236 +++++++++++++++++++++++
 tb/tb_usb_da_stream_fifo.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_da_pkg.sv
// usb_da_pkg
//   Shared definitions for the USB3 (FX3) receive path to DA sample path
//   stream buffer: USB read FSM state codes, the read-burst FSM state type
//   and the binary/Gray helpers used for pointer crossing.
//   The Gray helpers work on a fixed 32-bit word; callers size-cast their
//   pointers in and out, so any pointer up to 32 bits can use them.
package usb_da_pkg;

  // USB read FSM state codes (wrclock domain). Capture happens in USB_RD_DATA.
  localparam logic [3:0] USB_RD_IDLE      = 4'd0;
  localparam logic [3:0] USB_RD_WAIT_FLAG = 4'd1;
  localparam logic [3:0] USB_RD_ASSERT_CS = 4'd2;
  localparam logic [3:0] USB_RD_ADDR      = 4'd3;
  localparam logic [3:0] USB_RD_ASSERT_OE = 4'd4;
  localparam logic [3:0] USB_RD_ASSERT_RD = 4'd5;
  localparam logic [3:0] USB_RD_DATA      = 4'd6;
  localparam logic [3:0] USB_RD_DONE      = 4'd7;

  localparam int GRAY_W = 32;

  // Read-side burst FSM.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    BURST = 1'b1
  } rd_fsm_t;

  function automatic logic [GRAY_W-1:0] bin2gray(input logic [GRAY_W-1:0] bin);
    return bin ^ {1'b0, bin[GRAY_W-1:1]};
  endfunction

  function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] gray);
    logic [GRAY_W-1:0] bin;
    bin[GRAY_W-1] = gray[GRAY_W-1];
    for (int i = GRAY_W - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/sdp_ram_2clk.sv
// sdp_ram_2clk
//   Simple dual-port RAM, DATA_W x 2^ADDR_W, write port on wrclock and a
//   registered read port on rdclock. Array contents are not reset; only the
//   read output register is, so the stream output starts at zero.
// Ports:
//   wrclock, wr_en, wr_addr, wr_data : write port
//   rdclock, rd_rst_n                : read clock and its (already synchronised) reset
//   rd_en, rd_addr                   : read request, data appears on rd_data after the edge
//   rd_data                          : registered read data, holds while rd_en is low
module sdp_ram_2clk #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic              wrclock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rdclock,
  input  logic              rd_rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 32'd1 << ADDR_W;

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] rd_data_r;

  // Write port: store one word per enabled wrclock edge.
  always_ff @(posedge wrclock) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  // Read port: registered output that holds its value between reads.
  always_ff @(posedge rdclock or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_data_r <= {DATA_W{1'b0}};
    end else if (rd_en) begin
      rd_data_r <= mem_r[rd_addr];
    end
  end

  assign rd_data = rd_data_r;

endmodule

// File: rtl/usb_da_stream_fifo.sv
// usb_da_stream_fifo
//   Dual-clock stream buffer between the USB3 (FX3) receive path and the DA
//   sample path. Words are captured on wrclock while the USB read FSM is in
//   CAPTURE_STATE. A falling edge of USB3_FLAGA starts a BURST_LEN-word read
//   burst on rdclock, provided that many words are visible to the read side.
//   Pointers cross domains as registered Gray codes through 2-flop
//   synchronisers, so both full and empty decisions are conservative.
// Ports:
//   wrclock, rst_n      : write clock, async active-low reset (also resets rdclock side)
//   rdclock             : read / DA clock
//   data, usb_rd_state  : USB word and USB read FSM state (wrclock)
//   USB3_FLAGA          : asynchronous burst request, falling edge triggers
//   q, q_valid          : read data and its valid strobe (rdclock)
//   rd_busy             : a read burst is in progress (rdclock)
//   wr_full, wr_level   : write-side full flag and occupancy (wrclock)
//   overflow            : sticky, a word was dropped on full (wrclock)
//   underrun            : sticky, a trigger found too little data (rdclock)
module usb_da_stream_fifo
  import usb_da_pkg::*;
#(
  parameter int         DATA_W        = 32,
  parameter int         ADDR_W        = 8,
  parameter int         BURST_LEN     = 256,
  parameter logic [3:0] CAPTURE_STATE = USB_RD_DATA
) (
  input  logic              wrclock,
  input  logic              rst_n,
  input  logic              rdclock,
  input  logic [DATA_W-1:0] data,
  input  logic [3:0]        usb_rd_state,
  input  logic              USB3_FLAGA,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              rd_busy,
  output logic              wr_full,
  output logic [ADDR_W:0]   wr_level,
  output logic              overflow,
  output logic              underrun
);

  localparam int                 PTR_W       = ADDR_W + 1;
  localparam int                 DEPTH       = 32'd1 << ADDR_W;
  localparam logic [PTR_W-1:0]   DEPTH_V     = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0]   BURST_LEN_V = PTR_W'(BURST_LEN);
  localparam logic [PTR_W-1:0]   PTR_ONE     = PTR_W'(32'd1);
  localparam logic [PTR_W-1:0]   PTR_ZERO    = {PTR_W{1'b0}};

  // ---------------------------------------------------------------- write side
  logic             wr_req_s;
  logic             wr_en_s;
  logic             wr_full_s;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] wr_ptr_nxt_s;
  logic [PTR_W-1:0] wr_gray_r;
  logic [PTR_W-1:0] rd_gray_sync1_r;
  logic [PTR_W-1:0] rd_gray_sync2_r;
  logic [PTR_W-1:0] rd_ptr_sync_s;
  logic [PTR_W-1:0] wr_level_s;
  logic             overflow_r;

  // ----------------------------------------------------------------- read side
  logic             rd_rst_meta_r;
  logic             rd_rst_n_r;
  logic             flaga_sync1_r;
  logic             flaga_sync2_r;
  logic             flaga_dly_r;
  logic             trigger_s;
  logic [PTR_W-1:0] wr_gray_sync1_r;
  logic [PTR_W-1:0] wr_gray_sync2_r;
  logic [PTR_W-1:0] wr_ptr_sync_s;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] rd_ptr_nxt_s;
  logic [PTR_W-1:0] rd_gray_r;
  logic [PTR_W-1:0] rd_level_s;
  logic [PTR_W-1:0] cnt_r;
  logic [PTR_W-1:0] cnt_nxt_s;
  rd_fsm_t          state_r;
  rd_fsm_t          state_nxt_s;
  logic             rd_en_s;
  logic             underrun_set_s;
  logic             q_valid_r;
  logic             underrun_r;

  // Write-side decode: capture request, occupancy against the synchronised
  // read pointer, and the next write pointer.
  always_comb begin
    wr_req_s      = (usb_rd_state == CAPTURE_STATE);
    rd_ptr_sync_s = PTR_W'(gray2bin(GRAY_W'(rd_gray_sync2_r)));
    wr_level_s    = wr_ptr_r - rd_ptr_sync_s;
    wr_full_s     = (wr_level_s == DEPTH_V);
    wr_en_s       = wr_req_s && !wr_full_s;
    if (wr_en_s) begin
      wr_ptr_nxt_s = wr_ptr_r + PTR_ONE;
    end else begin
      wr_ptr_nxt_s = wr_ptr_r;
    end
  end

  // Write-domain state: pointer, its Gray image, read-pointer synchroniser
  // and the sticky overflow flag.
  always_ff @(posedge wrclock or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r        <= PTR_ZERO;
      wr_gray_r       <= PTR_ZERO;
      rd_gray_sync1_r <= PTR_ZERO;
      rd_gray_sync2_r <= PTR_ZERO;
      overflow_r      <= 1'b0;
    end else begin
      wr_ptr_r        <= wr_ptr_nxt_s;
      // Gray image tracks the pointer edge-for-edge so the read side sees
      // a write after the register plus two synchroniser flops.
      wr_gray_r       <= PTR_W'(bin2gray(GRAY_W'(wr_ptr_nxt_s)));
      rd_gray_sync1_r <= rd_gray_r;
      rd_gray_sync2_r <= rd_gray_sync1_r;
      if (wr_req_s && wr_full_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Read-domain reset: asserts with rst_n, releases two rdclock edges later.
  always_ff @(posedge rdclock or negedge rst_n) begin
    if (!rst_n) begin
      rd_rst_meta_r <= 1'b0;
      rd_rst_n_r    <= 1'b0;
    end else begin
      rd_rst_meta_r <= 1'b1;
      rd_rst_n_r    <= rd_rst_meta_r;
    end
  end

  // FLAGA synchroniser plus one delay stage for falling-edge detection, and
  // the write-pointer synchroniser.
  always_ff @(posedge rdclock or negedge rd_rst_n_r) begin
    if (!rd_rst_n_r) begin
      flaga_sync1_r   <= 1'b0;
      flaga_sync2_r   <= 1'b0;
      flaga_dly_r     <= 1'b0;
      wr_gray_sync1_r <= PTR_ZERO;
      wr_gray_sync2_r <= PTR_ZERO;
    end else begin
      flaga_sync1_r   <= USB3_FLAGA;
      flaga_sync2_r   <= flaga_sync1_r;
      flaga_dly_r     <= flaga_sync2_r;
      wr_gray_sync1_r <= wr_gray_r;
      wr_gray_sync2_r <= wr_gray_sync1_r;
    end
  end

  // Read FSM next-state: IDLE waits for a trigger with enough data, BURST
  // issues one read per cycle until the word counter is exhausted.
  // Triggers seen in BURST simply fall through and are lost.
  always_comb begin
    trigger_s      = !flaga_sync2_r && flaga_dly_r;
    wr_ptr_sync_s  = PTR_W'(gray2bin(GRAY_W'(wr_gray_sync2_r)));
    rd_level_s     = wr_ptr_sync_s - rd_ptr_r;
    state_nxt_s    = state_r;
    cnt_nxt_s      = cnt_r;
    rd_ptr_nxt_s   = rd_ptr_r;
    rd_en_s        = 1'b0;
    underrun_set_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (trigger_s) begin
          if (rd_level_s >= BURST_LEN_V) begin
            cnt_nxt_s   = BURST_LEN_V;
            state_nxt_s = BURST;
          end else begin
            underrun_set_s = 1'b1;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      BURST: begin
        rd_en_s      = 1'b1;
        rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
        cnt_nxt_s    = cnt_r - PTR_ONE;
        if (cnt_r == PTR_ONE) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = BURST;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Read-domain state: FSM, counter, pointer and its Gray image, output
  // strobe and the sticky underrun flag.
  always_ff @(posedge rdclock or negedge rd_rst_n_r) begin
    if (!rd_rst_n_r) begin
      state_r    <= IDLE;
      cnt_r      <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      rd_gray_r  <= PTR_ZERO;
      q_valid_r  <= 1'b0;
      underrun_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      rd_ptr_r   <= rd_ptr_nxt_s;
      rd_gray_r  <= PTR_W'(bin2gray(GRAY_W'(rd_ptr_nxt_s)));
      // The RAM registers the word on the same edge, so the strobe lines up.
      q_valid_r  <= rd_en_s;
      if (underrun_set_s) begin
        underrun_r <= 1'b1;
      end
    end
  end

  sdp_ram_2clk #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .wrclock  (wrclock),
    .wr_en    (wr_en_s),
    .wr_addr  (wr_ptr_r[ADDR_W-1:0]),
    .wr_data  (data),
    .rdclock  (rdclock),
    .rd_rst_n (rd_rst_n_r),
    .rd_en    (rd_en_s),
    .rd_addr  (rd_ptr_r[ADDR_W-1:0]),
    .rd_data  (q)
  );

  assign q_valid  = q_valid_r;
  assign rd_busy  = (state_r == BURST);
  assign wr_full  = wr_full_s;
  assign wr_level = wr_level_s;
  assign overflow = overflow_r;
  assign underrun = underrun_r;

endmodule

// File: tb/tb_usb_da_stream_fifo.sv
// tb_usb_da_stream_fifo
//   Directed bench for usb_da_stream_fifo with default parameters
//   (DATA_W=32, DEPTH=256, BURST_LEN=256). A table of scenario rows
//   (optional reset, clock half-periods, words to write, optional trigger,
//   expected burst contents and flags) is applied in a loop; the trigger
//   latency, re-trigger and reset-mid-burst cases are hand-written sequences.
module tb_usb_da_stream_fifo;

  localparam int BURST = 256;

  logic        wrclock = 1'b0;
  logic        rdclock = 1'b0;
  logic        rst_n;
  logic [31:0] data;
  logic [3:0]  usb_rd_state;
  logic        USB3_FLAGA;
  logic [31:0] q;
  logic        q_valid;
  logic        rd_busy;
  logic        wr_full;
  logic [8:0]  wr_level;
  logic        overflow;
  logic        underrun;

  int wr_half = 5;
  int rd_half = 7;
  int checks  = 0;
  int errors  = 0;

  logic [31:0] rx_q[$];

  typedef struct {
    bit rst;        // reset before this row
    int wr_half;
    int rd_half;
    int n_wr;       // words written (usb_rd_state = 6)
    int base;       // first data value written
    bit trig;       // drop FLAGA after the writes
    int exp_words;  // expected q_valid count
    int exp_first;  // expected first q, then incrementing
    bit exp_ovf;
    bit exp_und;
    int exp_level;  // wr_level once settled
    bit exp_full;
  } vec_t;

  vec_t vecs[8];
  vec_t v;

  usb_da_stream_fifo dut (
    .wrclock      (wrclock),
    .rst_n        (rst_n),
    .rdclock      (rdclock),
    .data         (data),
    .usb_rd_state (usb_rd_state),
    .USB3_FLAGA   (USB3_FLAGA),
    .q            (q),
    .q_valid      (q_valid),
    .rd_busy      (rd_busy),
    .wr_full      (wr_full),
    .wr_level     (wr_level),
    .overflow     (overflow),
    .underrun     (underrun)
  );

  initial forever #(wr_half) wrclock = ~wrclock;
  initial forever #(rd_half) rdclock = ~rdclock;

  // Collect every delivered word just after the rdclock edge.
  always @(posedge rdclock) begin
    #1;
    if (q_valid === 1'b1) begin
      rx_q.push_back(q);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_burst(input string name, input int n, input logic [31:0] first);
    int bad;
    bad = -1;
    chk({name, "_count"}, 64'(rx_q.size()), 64'(n));
    if (n > 0) begin
      for (int i = 0; i < rx_q.size() && i < n; i++) begin
        if (bad < 0 && rx_q[i] !== first + 32'(i)) begin
          bad = i;
        end
      end
      checks++;
      if (bad >= 0) begin
        errors++;
        $display("FAIL %s_data: word %0d actual=%0d required=%0d",
                 name, bad, rx_q[bad], first + 32'(bad));
      end
    end
  endtask

  task automatic do_reset();
    usb_rd_state = 4'd0;
    USB3_FLAGA   = 1'b1;
    rst_n        = 1'b0;
    repeat (3) @(negedge wrclock);
    repeat (3) @(negedge rdclock);
    rst_n = 1'b1;
    repeat (6) @(negedge rdclock);
    repeat (3) @(negedge wrclock);
  endtask

  task automatic do_writes(input int n, input logic [31:0] base);
    for (int i = 0; i < n; i++) begin
      @(negedge wrclock);
      usb_rd_state = 4'd6;
      data         = base + 32'(i);
    end
    @(negedge wrclock);
    usb_rd_state = 4'd0;
  endtask

  task automatic pulse_flaga();
    @(negedge rdclock);
    USB3_FLAGA = 1'b0;
    repeat (4) @(negedge rdclock);
    USB3_FLAGA = 1'b1;
  endtask

  initial begin
    // Field order: rst, wr_half, rd_half, n_wr, base, trig,
    //              exp_words, exp_first, exp_ovf, exp_und, exp_level, exp_full
    vecs[0] = '{1'b1, 5, 7, 256, 0,    1'b1, 256, 0,    1'b0, 1'b0, 0,   1'b0}; // plain burst
    vecs[1] = '{1'b0, 5, 7, 260, 0,    1'b0, 0,   0,    1'b1, 1'b0, 256, 1'b1}; // overfill
    vecs[2] = '{1'b0, 5, 7, 0,   0,    1'b1, 256, 0,    1'b1, 1'b0, 0,   1'b0}; // drain, no 256..259
    vecs[3] = '{1'b1, 5, 7, 100, 0,    1'b1, 0,   0,    1'b0, 1'b1, 100, 1'b0}; // underrun
    vecs[4] = '{1'b0, 5, 7, 156, 100,  1'b1, 256, 0,    1'b0, 1'b1, 0,   1'b0}; // top up, burst
    vecs[5] = '{1'b1, 10, 4, 256, 1000, 1'b1, 256, 1000, 1'b0, 1'b0, 0,  1'b0}; // slow wr, fast rd
    vecs[6] = '{1'b0, 3, 8, 256, 2000, 1'b1, 256, 2000, 1'b0, 1'b0, 0,   1'b0}; // fast wr, slow rd
    vecs[7] = '{1'b0, 5, 7, 256, 4000, 1'b1, 256, 4000, 1'b0, 1'b0, 0,   1'b0}; // past pointer wrap

    rst_n        = 1'b0;
    data         = 32'd0;
    usb_rd_state = 4'd0;
    USB3_FLAGA   = 1'b1;
    repeat (4) @(negedge wrclock);
    chk("rst_q",        64'(q),        64'd0);
    chk("rst_q_valid",  64'(q_valid),  64'd0);
    chk("rst_rd_busy",  64'(rd_busy),  64'd0);
    chk("rst_wr_full",  64'(wr_full),  64'd0);
    chk("rst_wr_level", 64'(wr_level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_underrun", 64'(underrun), 64'd0);
    rst_n = 1'b1;
    repeat (6) @(negedge rdclock);

    for (int r = 0; r < 8; r++) begin
      v       = vecs[r];
      wr_half = v.wr_half;
      rd_half = v.rd_half;
      if (v.rst) begin
        do_reset();
      end
      do_writes(v.n_wr, 32'(v.base));
      repeat (8) @(negedge rdclock);
      rx_q.delete();
      if (v.trig) begin
        pulse_flaga();
        repeat (BURST + 20) @(negedge rdclock);
      end
      repeat (10) @(negedge wrclock);
      chk_burst($sformatf("row%0d_burst", r), v.exp_words, 32'(v.exp_first));
      chk($sformatf("row%0d_overflow", r), 64'(overflow), 64'(v.exp_ovf));
      chk($sformatf("row%0d_underrun", r), 64'(underrun), 64'(v.exp_und));
      chk($sformatf("row%0d_wr_level", r), 64'(wr_level), 64'(v.exp_level));
      chk($sformatf("row%0d_wr_full", r),  64'(wr_full),  64'(v.exp_full));
      chk($sformatf("row%0d_rd_busy", r),  64'(rd_busy),  64'd0);
    end

    // Trigger latency and re-trigger during a burst.
    wr_half = 5;
    rd_half = 7;
    do_writes(256, 32'd3000);
    repeat (8) @(negedge rdclock);
    rx_q.delete();
    @(negedge rdclock);
    USB3_FLAGA = 1'b0;
    @(posedge rdclock); #1;  // edge 1 samples FLAGA low
    @(posedge rdclock); #1;  // edge 2, trigger decoded
    chk("lat_e2_rd_busy", 64'(rd_busy), 64'd0);
    @(posedge rdclock); #1;  // edge 3, BURST entered
    chk("lat_e3_rd_busy", 64'(rd_busy), 64'd1);
    chk("lat_e3_q_valid", 64'(q_valid), 64'd0);
    @(posedge rdclock); #1;  // edge 4, first word out
    chk("lat_e4_q_valid", 64'(q_valid), 64'd1);
    chk("lat_e4_q",       64'(q),       64'd3000);
    repeat (40) @(negedge rdclock);
    USB3_FLAGA = 1'b1;
    repeat (3) @(negedge rdclock);
    USB3_FLAGA = 1'b0;
    repeat (3) @(negedge rdclock);
    USB3_FLAGA = 1'b1;
    repeat (30) @(negedge rdclock);
    USB3_FLAGA = 1'b0;
    repeat (3) @(negedge rdclock);
    USB3_FLAGA = 1'b1;
    repeat (BURST + 20) @(negedge rdclock);
    chk_burst("retrig_burst", 256, 32'd3000);
    chk("retrig_underrun", 64'(underrun), 64'd0);
    chk("retrig_rd_busy",  64'(rd_busy),  64'd0);

    // Reset in the middle of a burst, then a clean fill-and-burst.
    do_writes(256, 32'd7000);
    repeat (8) @(negedge rdclock);
    rx_q.delete();
    pulse_flaga();
    for (int k = 0; k < 600; k++) begin
      if (rx_q.size() >= 40) break;
      @(negedge rdclock);
    end
    chk("midrst_reach40", 64'(rx_q.size() >= 40), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_q_valid",  64'(q_valid),  64'd0);
    chk("midrst_rd_busy",  64'(rd_busy),  64'd0);
    chk("midrst_wr_level", 64'(wr_level), 64'd0);
    chk("midrst_q",        64'(q),        64'd0);
    repeat (3) @(negedge rdclock);
    repeat (3) @(negedge wrclock);
    rst_n = 1'b1;
    repeat (6) @(negedge rdclock);
    do_writes(256, 32'd9000);
    repeat (8) @(negedge rdclock);
    rx_q.delete();
    pulse_flaga();
    repeat (BURST + 20) @(negedge rdclock);
    repeat (10) @(negedge wrclock);
    chk_burst("postrst_burst", 256, 32'd9000);
    chk("postrst_wr_level", 64'(wr_level), 64'd0);
    chk("postrst_underrun", 64'(underrun), 64'd0);
    chk("postrst_overflow", 64'(overflow), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
